rca_64_bit: RTL and testbench



---
 rtl/rca_64_bit.sv | 201 ++++++++++++++++++++
 tb/tb_rca_64_bit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/rca_64_bit.sv
// Registered 64-bit unsigned ripple-carry adder: {carry_out, sum} = x + y + carry_in.
// Latency: 1 cycle (inputs before edge N appear on outputs after edge N); 1 result/cycle.
// Backpressure: none; no enable or handshake, a new operation is accepted every cycle.
//
// The datapath is a strict full-adder ripple: 64 = 4 x 16, 16 = 4 x 4, 4 = 4 x 1.
// No lookahead, carry-select or '+' operator is used. This adder is the area and
// critical-path baseline for the faster adders. Its worst path runs from
// x[0]/y[0]/carry_in through all 64 carry stages to sum[63]/carry_out.

module rca_64_bit (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] x,
  input  logic [63:0] y,
  input  logic        carry_in,
  output logic [63:0] sum,
  output logic        carry_out
);

  // Carries between the four 16-bit slices; c_blk[0] is the external carry-in.
  logic [4:0]  c_blk;
  logic [63:0] s_core;

  logic [63:0] sum_d;
  logic [63:0] sum_q;
  logic        carry_out_d;
  logic        carry_out_q;

  assign c_blk[0] = carry_in;

  rca_16_bit u_blk0 (
    .a   (x[15:0]),
    .b   (y[15:0]),
    .ci  (c_blk[0]),
    .s   (s_core[15:0]),
    .co  (c_blk[1])
  );

  rca_16_bit u_blk1 (
    .a   (x[31:16]),
    .b   (y[31:16]),
    .ci  (c_blk[1]),
    .s   (s_core[31:16]),
    .co  (c_blk[2])
  );

  rca_16_bit u_blk2 (
    .a   (x[47:32]),
    .b   (y[47:32]),
    .ci  (c_blk[2]),
    .s   (s_core[47:32]),
    .co  (c_blk[3])
  );

  rca_16_bit u_blk3 (
    .a   (x[63:48]),
    .b   (y[63:48]),
    .ci  (c_blk[3]),
    .s   (s_core[63:48]),
    .co  (c_blk[4])
  );

  // Next-state for the output registers: the raw ripple result.
  always_comb begin
    sum_d       = s_core;
    carry_out_d = c_blk[4];
  end

  // Output registers; reset wins over any input and discards the in-flight result.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q       <= 64'h0;
      carry_out_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      carry_out_q <= carry_out_d;
    end
  end

  assign sum       = sum_q;
  assign carry_out = carry_out_q;

endmodule

// 16-bit ripple slice built from four 4-bit slices.
// Latency: combinational.
// Backpressure: none.
module rca_16_bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        ci,
  output logic [15:0] s,
  output logic        co
);

  logic [4:0] c;

  assign c[0] = ci;

  rca_4_bit u_nib0 (
    .a   (a[3:0]),
    .b   (b[3:0]),
    .ci  (c[0]),
    .s   (s[3:0]),
    .co  (c[1])
  );

  rca_4_bit u_nib1 (
    .a   (a[7:4]),
    .b   (b[7:4]),
    .ci  (c[1]),
    .s   (s[7:4]),
    .co  (c[2])
  );

  rca_4_bit u_nib2 (
    .a   (a[11:8]),
    .b   (b[11:8]),
    .ci  (c[2]),
    .s   (s[11:8]),
    .co  (c[3])
  );

  rca_4_bit u_nib3 (
    .a   (a[15:12]),
    .b   (b[15:12]),
    .ci  (c[3]),
    .s   (s[15:12]),
    .co  (c[4])
  );

  assign co = c[4];

endmodule

// 4-bit ripple slice built from four full adders.
// Latency: combinational.
// Backpressure: none.
module rca_4_bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [4:0] c;

  assign c[0] = ci;

  rca_full_adder u_fa0 (
    .a   (a[0]),
    .b   (b[0]),
    .ci  (c[0]),
    .s   (s[0]),
    .co  (c[1])
  );

  rca_full_adder u_fa1 (
    .a   (a[1]),
    .b   (b[1]),
    .ci  (c[1]),
    .s   (s[1]),
    .co  (c[2])
  );

  rca_full_adder u_fa2 (
    .a   (a[2]),
    .b   (b[2]),
    .ci  (c[2]),
    .s   (s[2]),
    .co  (c[3])
  );

  rca_full_adder u_fa3 (
    .a   (a[3]),
    .b   (b[3]),
    .ci  (c[3]),
    .s   (s[3]),
    .co  (c[4])
  );

  assign co = c[4];

endmodule

// One-bit full adder; the carry depends only on this bit's operands and carry-in.
// Latency: combinational.
// Backpressure: none.
module rca_full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: tb/tb_rca_64_bit.sv
// Bench for rca_64_bit: directed corner cases plus a long random back-to-back run.
// Expected results come from 65-bit integer arithmetic on the applied operands.
// Inputs change 1ns after each rising edge; outputs are sampled at the same point.

module tb_rca_64_bit;

  logic        clk;
  logic        rst;
  logic [63:0] x;
  logic [63:0] y;
  logic        carry_in;
  logic [63:0] sum;
  logic        carry_out;

  int total;
  int bad;

  localparam logic [63:0] ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  rca_64_bit dut (
    .clk       (clk),
    .rst       (rst),
    .x         (x),
    .y         (y),
    .carry_in  (carry_in),
    .sum       (sum),
    .carry_out (carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain 65-bit unsigned addition.
  function automatic logic [64:0] ref_add(input logic [63:0] a, input logic [63:0] b,
                                          input logic c);
    logic [64:0] r;
    r = {1'b0, a} + {1'b0, b} + {64'h0, c};
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; x = 64'd5; y = 64'd7; carry_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if ({carry_out, sum} !== 65'h0) begin
        bad++;
        $display("FAIL reset_hold[%0d]: got cout=%0b sum=%0d, want cout=0 sum=0", i, carry_out, sum);
      end
    end
    rst = 1'b0;
    step();
    total++;
    if ({carry_out, sum} !== {1'b0, 64'd13}) begin
      bad++;
      $display("FAIL reset_release: got cout=%0b sum=%0d, want cout=0 sum=13", carry_out, sum);
    end
  endtask

  task automatic test_plain_adds();
    logic [63:0] xs [6];
    logic [63:0] ys [6];
    logic        cs [6];
    logic [63:0] es [6];
    xs = '{64'd420000021, 64'd12500002, 64'd14302310, 64'd11409567, 64'd42967295, 64'd42944560};
    ys = '{64'd500009800, 64'd31030099, 64'd220098098, 64'd20032123, 64'd10055555, 64'd1729550};
    cs = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    es = '{64'd920009821, 64'd43530102, 64'd234400408, 64'd31441691, 64'd53022850, 64'd44674110};
    for (int i = 0; i < 6; i++) begin
      x = xs[i]; y = ys[i]; carry_in = cs[i];
      step();
      total++;
      if ({carry_out, sum} !== {1'b0, es[i]}) begin
        bad++;
        $display("FAIL plain_add[%0d]: got cout=%0b sum=%0d, want cout=0 sum=%0d",
                 i, carry_out, sum, es[i]);
      end
    end
  endtask

  task automatic test_wrap();
    x = ALL_ONES; y = 64'd1; carry_in = 1'b0;
    step();
    total++;
    if ({carry_out, sum} !== {1'b1, 64'd0}) begin
      bad++;
      $display("FAIL wrap_cin0: got cout=%0b sum=%h, want cout=1 sum=0", carry_out, sum);
    end
    carry_in = 1'b1;
    step();
    total++;
    if ({carry_out, sum} !== {1'b1, 64'd1}) begin
      bad++;
      $display("FAIL wrap_cin1: got cout=%0b sum=%h, want cout=1 sum=1", carry_out, sum);
    end
  endtask

  task automatic test_critical_path();
    x = ALL_ONES; y = ALL_ONES; carry_in = 1'b1;
    step();
    total++;
    if ({carry_out, sum} !== {1'b1, ALL_ONES}) begin
      bad++;
      $display("FAIL full_propagate: got cout=%0b sum=%h, want cout=1 sum=%h", carry_out, sum, ALL_ONES);
    end
    // Single carry entering at bit 0 must ripple all the way to carry_out.
    x = ALL_ONES; y = 64'd0; carry_in = 1'b1;
    step();
    total++;
    if ({carry_out, sum} !== {1'b1, 64'd0}) begin
      bad++;
      $display("FAIL cin_ripple: got cout=%0b sum=%h, want cout=1 sum=0", carry_out, sum);
    end
  endtask

  task automatic test_mid_reset();
    x = ALL_ONES; y = 64'd1; carry_in = 1'b0; rst = 1'b1;
    step();
    total++;
    if ({carry_out, sum} !== 65'h0) begin
      bad++;
      $display("FAIL mid_reset: got cout=%0b sum=%h, want cout=0 sum=0", carry_out, sum);
    end
    rst = 1'b0; x = 64'd3; y = 64'd4; carry_in = 1'b0;
    step();
    total++;
    if ({carry_out, sum} !== {1'b0, 64'd7}) begin
      bad++;
      $display("FAIL after_mid_reset: got cout=%0b sum=%0d, want cout=0 sum=7", carry_out, sum);
    end
  endtask

  task automatic test_back_to_back();
    logic [64:0] exp;
    int          errs_here;
    errs_here = 0;
    for (int i = 0; i < 10000; i++) begin
      x        = {$urandom, $urandom};
      y        = {$urandom, $urandom};
      carry_in = 1'($urandom);
      // Occasionally force long propagate runs.
      if ($urandom_range(0, 15) == 0) y = ~x;
      exp = ref_add(x, y, carry_in);
      step();
      total++;
      if ({carry_out, sum} !== exp) begin
        bad++;
        errs_here++;
        if (errs_here <= 10)
          $display("FAIL random[%0d]: x=%h y=%h cin=%0b got cout=%0b sum=%h, want cout=%0b sum=%h",
                   i, x, y, carry_in, carry_out, sum, exp[64], exp[63:0]);
      end
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    x        = 64'd0;
    y        = 64'd0;
    carry_in = 1'b0;
    #1;
    test_reset();
    test_plain_adds();
    test_wrap();
    test_critical_path();
    test_mid_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
